serial_add_sub32: RTL
=====================

SERIAL_ADD_SUB32 -- requirements
Module: serial_add_sub32

Interface
REQ-001 The block SHALL have exactly one clock; reset SHALL be asynchronous and active-low.
REQ-002 Parameter STEP, default 1, bits processed per cycle; legal values 1, 2, 4, 8.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operand request valid.
REQ-006 in_ready  output  1  block can accept an operand request.
REQ-007 A  input  32  first operand.
REQ-008 B  input  32  second operand.
REQ-009 sel  input  1  0 = A+B, 1 = A-B.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 S  output  32  result, modulo 2^32.
REQ-013 cout  output  1  carry out; for subtract, 1 = no borrow.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 Accept (in_valid & in_ready) at a rising edge SHALL capture A, B XOR {32{sel}} and carry-in = sel, clear the cycle counter, and move to RUN.
REQ-017 Each RUN cycle SHALL add the STEP LSBs of the operand registers plus the carry, shift the sum into S from the MSB side, and update the carry.
REQ-018 After exactly 32/STEP RUN cycles the FSM SHALL enter DONE, so out_valid rises 32/STEP edges after the accepting edge.
REQ-019 In DONE, S and cout SHALL hold stable until out_valid & out_ready; that edge SHALL return the FSM to IDLE.
REQ-020 out_ready SHALL be ignored outside DONE.
REQ-021 in_valid SHALL be ignored outside IDLE, and operands SHALL not change while busy.
REQ-022 Overflow beyond 32 bits SHALL wrap silently; only cout reports it.
REQ-023 Back-to-back operation: a new request SHALL be accepted one cycle after the result handshake, at the earliest (no accept in the same cycle as the result handshake).

Reset
REQ-024 While rst_n = 0, state SHALL be IDLE, in_ready = 1, out_valid = 0, S = 0, cout = 0, and the counter and operand registers SHALL be 0.
REQ-025 Reset asserted during RUN or DONE SHALL abort the operation with no result produced.

Configuration
REQ-026 Macro SERIAL_ADD_SUB_OVF_EN defined: the block SHALL add output port ovf (output, 1 bit) giving signed two's-complement overflow, computed as the carry-in of the MSB XOR the carry-out of the MSB; ovf is valid with out_valid, and its reset value is 0.
REQ-027 Macro SERIAL_ADD_SUB_OVF_EN undefined: port ovf and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 Package add_sub_pkg SHALL hold the WIDTH = 32 constant, the state typedef (IDLE/RUN/DONE), and the opcode constants OP_ADD = 0 and OP_SUB = 1.
REQ-029 Sub-module add_sub_slice SHALL implement the combinational STEP-bit ripple adder (inputs a, b, cin; outputs sum, cout, and the MSB carry-in for ovf), instantiated once.

Verification
REQ-030 STEP = 1, A = 1, B = 1, sel = 0 -> S = 0x00000002, cout = 0, with out_valid exactly 32 cycles after accept.
REQ-031 A = 2, B = 1, sel = 1 -> S = 0x00000001, cout = 1; A = 0, B = 1, sel = 1 -> S = 0xFFFFFFFF, cout = 0.
REQ-032 A = 0xFFFFFFFF, B = 1, sel = 0 -> S = 0, cout = 1; repeat with STEP = 4 -> same result after 8 cycles.
REQ-033 out_ready held 0 for 5 cycles in DONE with in_valid = 1 and new operands -> S stable, in_ready = 0, no new accept; out_ready = 1 -> IDLE next edge.
REQ-034 rst_n pulsed low at RUN cycle 10 -> out_valid = 0, in_ready = 1, S = 0 immediately; the next request completes correctly.
REQ-035 With SERIAL_ADD_SUB_OVF_EN: 0x7FFFFFFF + 1 -> ovf = 1; 0x80000000 - 1 -> ovf = 1; 5 - 3 -> ovf = 0.

Source files
------------

// File: rtl/add_sub_pkg.sv
// Shared constants and types for the bit-serial 32-bit adder/subtractor.
package add_sub_pkg;

  localparam int WIDTH = 32;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add_sub_slice.sv
// Combinational STEP-bit ripple slice: sum, carry out and the carry into the slice MSB.
module add_sub_slice #(
  parameter int STEP = 1
) (
  input  logic [STEP-1:0] a,
  input  logic [STEP-1:0] b,
  input  logic            cin,
  output logic [STEP-1:0] sum,
  output logic            cout,
  output logic            cmsb
);

  logic [STEP:0] total;

  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{STEP{1'b0}}, cin};
  end

  assign sum  = total[STEP-1:0];
  assign cout = total[STEP];
  // Carry into the MSB recovered from the MSB sum bit.
  assign cmsb = a[STEP-1] ^ b[STEP-1] ^ total[STEP-1];

endmodule

// File: rtl/serial_add_sub32.sv
// Bit-serial 32-bit add/subtract, STEP bits per cycle, valid/ready on both sides.
// Optional signed-overflow port ovf enabled by defining SERIAL_ADD_SUB_OVF_EN.
module serial_add_sub32
  import add_sub_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout
`ifdef SERIAL_ADD_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CYCLES = WIDTH / STEP;
  localparam int CW     = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [STEP-1:0]  slice_sum;
  logic             slice_cout;
  logic             slice_cmsb;
  logic             accept;

  assign accept = (state_q == IDLE) && in_valid;

  add_sub_slice #(.STEP(STEP)) u_slice (
    .a    (a_q[STEP-1:0]),
    .b    (b_q[STEP-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout),
    .cmsb (slice_cmsb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)       state_d = RUN;
      RUN:     if (cnt_q == LAST)  state_d = DONE;
      DONE:    if (out_ready)      state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Subtract is A + ~B + 1: invert B once at capture and seed the carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_q     <= A;
      b_q     <= B ^ {WIDTH{sel}};
      carry_q <= (sel == OP_SUB);
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      a_q     <= a_q >> STEP;
      b_q     <= b_q >> STEP;
      s_q     <= {slice_sum, s_q[WIDTH-1:STEP]};
      carry_q <= slice_cout;
      cnt_q   <= cnt_q + CW'(1);
    end
  end

  assign S    = s_q;
  assign cout = carry_q;

`ifdef SERIAL_ADD_SUB_OVF_EN
  logic ovf_q;

  // The last RUN cycle processes the MSB, so its value is the one left standing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              ovf_q <= 1'b0;
    else if (state_q == RUN) ovf_q <= slice_cmsb ^ slice_cout;
  end

  assign ovf = ovf_q;
`else
  logic unused_cmsb;
  assign unused_cmsb = slice_cmsb;
`endif

endmodule
